// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: NOP encoding and
// default PC step used by the fetch front end and its storage.
package if_fetch_queue_pkg;

    // Canonical RV32 NOP (addi x0, x0, 0) presented to decode when empty
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    // Default sequential PC increment for 32-bit instructions
    localparam int unsigned DEF_PC_STEP = 4;

endpackage

// File: rtl/if_fetch_queue_storage.sv
// Circular buffer for the fetch queue: DEPTH entries of W bits with
// head/tail pointers and an occupancy count. The head entry is read
// combinationally. A clear wins over push and pop in the same cycle.
module ifq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    // Entry array: write the tail slot on push (clear only moves pointers)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push && !clear) begin
            mem_r[tail_r] <= push_data;
        end else begin
            mem_r[tail_r] <= mem_r[tail_r];
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop) begin
                head_r <= head_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[head_r];
    assign count     = count_r;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues reads to a
// 1-cycle-latency instruction memory and buffers {instr, pc} in a queue
// that decode drains over valid/ready. Redirect flushes and refetches.
// Optional build macro FETCH_STATS_EN adds saturating stall and
// redirect counters (o_stall_cnt, o_redirect_cnt).
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          NB_PC    = 32,
    parameter int          NB_INSTR = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = DEF_PC_STEP
`ifdef FETCH_STATS_EN
    ,
    parameter int          NB_CNT   = 16
`endif
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_redirect,
    input  logic [NB_PC-1:0]         i_redirect_pc,
    output logic [NB_PC-1:0]         o_imem_raddr,
    output logic                     o_imem_ren,
    input  logic [NB_INSTR-1:0]      i_imem_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NB_INSTR-1:0]      o_instr,
    output logic [NB_PC-1:0]         o_pc,
    output logic [NB_PC-1:0]         o_pc_next,
    output logic [$clog2(DEPTH):0]   o_count
`ifdef FETCH_STATS_EN
    ,
    output logic [NB_CNT-1:0]        o_stall_cnt,
    output logic [NB_CNT-1:0]        o_redirect_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = NB_INSTR + NB_PC;

    logic [NB_PC-1:0]    fetch_pc_r;
    logic                inflight_r;
    logic [NB_PC-1:0]    inflight_pc_r;

    logic [CW-1:0]       count_s;
    logic                valid_s;
    logic                pop_s;
    logic                push_s;
    logic                issue_s;
    logic [CW:0]         credit_s;
    logic [EW-1:0]       head_s;
    logic [NB_INSTR-1:0] head_instr_s;
    logic [NB_PC-1:0]    head_pc_s;

    ifq_storage #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_storage (
        .clk       (clk),
        .rst       (i_rst),
        .clear     (i_redirect),
        .push      (push_s),
        .push_data ({i_imem_data, inflight_pc_r}),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s)
    );

    // Handshake and credit: a read is only issued when the queue is sure
    // to have room for it, counting the response already in flight.
    always_comb begin
        valid_s  = (count_s != CW'(0));
        pop_s    = valid_s & i_ready & i_en & ~i_redirect;
        // The memory answers regardless of i_en, so the response is kept
        push_s   = inflight_r & ~i_redirect;
        credit_s = (CW+1)'(count_s) + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
        if (credit_s < (CW+1)'(DEPTH)) begin
            issue_s = ~i_rst & i_en & ~i_redirect;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Fetch PC and in-flight tracking; redirect discards the pending read
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_r    <= NB_PC'(RESET_PC);
            inflight_r    <= 1'b0;
            inflight_pc_r <= {NB_PC{1'b0}};
        end else if (i_redirect) begin
            fetch_pc_r    <= i_redirect_pc;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end else if (issue_s) begin
            fetch_pc_r    <= fetch_pc_r + NB_PC'(PC_STEP);
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
        end else begin
            fetch_pc_r    <= fetch_pc_r;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end
    end

    // Head presentation: a NOP with zero PCs whenever the queue is empty
    always_comb begin
        head_instr_s = head_s[EW-1:NB_PC];
        head_pc_s    = head_s[NB_PC-1:0];
        if (valid_s) begin
            o_instr   = head_instr_s;
            o_pc      = head_pc_s;
            o_pc_next = head_pc_s + NB_PC'(PC_STEP);
        end else begin
            o_instr   = NB_INSTR'(NOP_INSTR);
            o_pc      = {NB_PC{1'b0}};
            o_pc_next = {NB_PC{1'b0}};
        end
    end

    assign o_imem_raddr = fetch_pc_r;
    assign o_imem_ren   = issue_s;
    assign o_valid      = valid_s;
    assign o_count      = count_s;

`ifdef FETCH_STATS_EN
    logic [NB_CNT-1:0] stall_cnt_r;
    logic [NB_CNT-1:0] redirect_cnt_r;

    // Saturating counters: empty-while-enabled cycles and redirect cycles
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_r    <= {NB_CNT{1'b0}};
            redirect_cnt_r <= {NB_CNT{1'b0}};
        end else begin
            if (i_en && !valid_s && (stall_cnt_r != {NB_CNT{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + NB_CNT'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (i_redirect && (redirect_cnt_r != {NB_CNT{1'b1}})) begin
                redirect_cnt_r <= redirect_cnt_r + NB_CNT'(1);
            end else begin
                redirect_cnt_r <= redirect_cnt_r;
            end
        end
    end

    assign o_stall_cnt    = stall_cnt_r;
    assign o_redirect_cnt = redirect_cnt_r;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue (DEPTH=4). Instruction memory
// model returns word k = 0x1000 + k one cycle after a read strobe.
// Stats checks are compiled only with FETCH_STATS_EN (NB_CNT=4).
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_imem_raddr;
    logic        o_imem_ren;
    logic [31:0] i_imem_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_next;
    logic [2:0]  o_count;
`ifdef FETCH_STATS_EN
    logic [3:0]  o_stall_cnt;
    logic [3:0]  o_redirect_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .DEPTH (4)
`ifdef FETCH_STATS_EN
        ,
        .NB_CNT (4)
`endif
    ) dut (
        .clk            (clk),
        .i_rst          (i_rst),
        .i_en           (i_en),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_imem_raddr   (o_imem_raddr),
        .o_imem_ren     (o_imem_ren),
        .i_imem_data    (i_imem_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_instr        (o_instr),
        .o_pc           (o_pc),
        .o_pc_next      (o_pc_next),
        .o_count        (o_count)
`ifdef FETCH_STATS_EN
        ,
        .o_stall_cnt    (o_stall_cnt),
        .o_redirect_cnt (o_redirect_cnt)
`endif
    );

    // 1-cycle-latency instruction memory model
    always_ff @(posedge clk) begin
        if (o_imem_ren) begin
            i_imem_data <= 32'h0000_1000 + (o_imem_raddr >> 2);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold reset two edges, release; returns with cycle 0 settled
    task automatic start(input logic ready);
        i_rst = 1'b1; i_en = 1'b1; i_ready = ready;
        i_redirect = 1'b0; i_redirect_pc = 32'h0;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_en = 1'b1; i_ready = 1'b1;
        i_redirect = 1'b0; i_redirect_pc = 32'h0;
        tick();
        #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", o_valid); end
        checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", o_count); end
        checks++; if (o_imem_ren !== 1'b0) begin failures++; $display("FAIL rst_ren got=%0b exp=0", o_imem_ren); end
        checks++; if (o_instr !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", o_instr, NOP); end
        checks++; if (o_pc !== 32'h0 || o_pc_next !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h/%h exp=0/0", o_pc, o_pc_next); end
`ifdef FETCH_STATS_EN
        checks++; if (o_stall_cnt !== 4'd0 || o_redirect_cnt !== 4'd0) begin failures++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", o_stall_cnt, o_redirect_cnt); end
`endif
    endtask

    task automatic test_stream;
        start(1'b1);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            checks++;
            if (o_imem_ren !== 1'b1 || o_imem_raddr !== 32'(4 * c)) begin
                failures++; $display("FAIL stream_issue c=%0d got=%0b/%h exp=1/%h", c, o_imem_ren, o_imem_raddr, 32'(4 * c));
            end
            checks++;
            if (c < 2) begin
                if (o_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid c=%0d got=%0b exp=0", c, o_valid); end
            end else if (o_valid !== 1'b1 || o_instr !== 32'h1000 + 32'(c - 2) ||
                         o_pc !== 32'(4 * (c - 2)) || o_pc_next !== 32'(4 * (c - 1))) begin
                failures++; $display("FAIL stream_head c=%0d got=%0b/%h/%h/%h exp=1/%h/%h/%h", c, o_valid, o_instr, o_pc, o_pc_next,
                                     32'h1000 + 32'(c - 2), 32'(4 * (c - 2)), 32'(4 * (c - 1)));
            end
        end
    endtask

    task automatic test_backpressure;
        int issues;
        issues = 0;
        start(1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            if (o_imem_ren) issues++;
        end
        checks++; if (issues != 4) begin failures++; $display("FAIL bp_issues got=%0d exp=4", issues); end
        checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", o_count); end
        checks++; if (o_imem_ren !== 1'b0) begin failures++; $display("FAIL bp_full_ren got=%0b exp=0", o_imem_ren); end
        tick();
        i_ready = 1'b1;
        #1;
        checks++; if (o_imem_ren !== 1'b1 || o_imem_raddr !== 32'h10) begin failures++; $display("FAIL bp_resume got=%0b/%h exp=1/10", o_imem_ren, o_imem_raddr); end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'(4 * k) || o_instr !== 32'h1000 + 32'(k)) begin
                failures++; $display("FAIL bp_drain k=%0d got=%0b/%h/%h exp=1/%h/%h", k, o_valid, o_pc, o_instr, 32'(4 * k), 32'h1000 + 32'(k));
            end
        end
    endtask

    task automatic test_redirect;
        start(1'b0);
        tick(); tick(); tick();
        tick();
        i_redirect = 1'b1; i_redirect_pc = 32'h40; i_ready = 1'b1;
        #1;
        checks++; if (o_count !== 3'd3 || o_imem_ren !== 1'b0) begin failures++; $display("FAIL redir_cycle got=%0d/%0b exp=3/0", o_count, o_imem_ren); end
        tick();
        i_redirect = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL redir_flush got=%0b/%0d exp=0/0", o_valid, o_count); end
        checks++; if (o_imem_ren !== 1'b1 || o_imem_raddr !== 32'h40) begin failures++; $display("FAIL redir_issue got=%0b/%h exp=1/40", o_imem_ren, o_imem_raddr); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL redir_drop got=%0b/%0d exp=0/0", o_valid, o_count); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_instr !== 32'h1010) begin failures++; $display("FAIL redir_first got=%0b/%h/%h exp=1/40/1010", o_valid, o_pc, o_instr); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h44 || o_instr !== 32'h1011) begin failures++; $display("FAIL redir_second got=%0b/%h/%h exp=1/44/1011", o_valid, o_pc, o_instr); end
    endtask

    task automatic test_enable_drop;
        start(1'b1);
        tick(); tick();
        tick();
        i_en = 1'b0;
        #1;
        checks++; if (o_imem_ren !== 1'b0 || o_count !== 3'd1 || o_pc !== 32'h4) begin failures++; $display("FAIL en_drop got=%0b/%0d/%h exp=0/1/4", o_imem_ren, o_count, o_pc); end
        tick();
        checks++; if (o_imem_ren !== 1'b0 || o_count !== 3'd2 || o_pc !== 32'h4) begin failures++; $display("FAIL en_push got=%0b/%0d/%h exp=0/2/4", o_imem_ren, o_count, o_pc); end
        tick();
        checks++; if (o_count !== 3'd2 || o_pc !== 32'h4 || o_valid !== 1'b1) begin failures++; $display("FAIL en_hold got=%0d/%h/%0b exp=2/4/1", o_count, o_pc, o_valid); end
        tick();
        i_en = 1'b1;
        #1;
        checks++; if (o_imem_ren !== 1'b1 || o_imem_raddr !== 32'hC) begin failures++; $display("FAIL en_resume got=%0b/%h exp=1/c", o_imem_ren, o_imem_raddr); end
        for (int k = 1; k < 6; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'(4 * k) || o_instr !== 32'h1000 + 32'(k)) begin
                failures++; $display("FAIL en_order k=%0d got=%0b/%h/%h exp=1/%h/%h", k, o_valid, o_pc, o_instr, 32'(4 * k), 32'h1000 + 32'(k));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        start(1'b0);
        tick(); tick(); tick();
        checks++; if (o_count !== 3'd2) begin failures++; $display("FAIL rmid_pre got=%0d exp=2", o_count); end
        i_rst = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0 || o_count !== 3'd0 || o_imem_ren !== 1'b0 || o_instr !== NOP) begin
            failures++; $display("FAIL rmid_async got=%0b/%0d/%0b/%h exp=0/0/0/%h", o_valid, o_count, o_imem_ren, o_instr, NOP);
        end
        tick();
        i_rst = 1'b0;
        #1;
        checks++; if (o_imem_ren !== 1'b1 || o_imem_raddr !== 32'h0 || o_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_restart got=%0b/%h/%0b exp=1/0/0", o_imem_ren, o_imem_raddr, o_valid);
        end
        tick(); tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== 32'h1000) begin
            failures++; $display("FAIL rmid_first got=%0b/%h/%h exp=1/0/1000", o_valid, o_pc, o_instr);
        end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats;
        start(1'b1);
        for (int c = 0; c < 20; c++) begin
            if (c > 0) tick();
            i_redirect = (c % 2 == 0); i_redirect_pc = 32'h40;
            #1;
            if (c == 14) begin
                checks++; if (o_stall_cnt !== 4'd14) begin failures++; $display("FAIL stall_mid got=%0d exp=14", o_stall_cnt); end
            end
        end
        tick();
        i_redirect = 1'b0;
        #1;
        checks++; if (o_stall_cnt !== 4'd15) begin failures++; $display("FAIL stall_sat got=%0d exp=15", o_stall_cnt); end
        checks++; if (o_redirect_cnt !== 4'd10) begin failures++; $display("FAIL redir_cnt10 got=%0d exp=10", o_redirect_cnt); end
        start(1'b1);
        i_redirect = 1'b1; #1;
        tick(); i_redirect = 1'b0; #1;
        tick(); i_redirect = 1'b1; #1;
        tick(); i_redirect = 1'b0; #1;
        checks++; if (o_redirect_cnt !== 4'd2) begin failures++; $display("FAIL redir_cnt2 got=%0d exp=2", o_redirect_cnt); end
    endtask
`endif

    initial begin
        i_imem_data = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_enable_drop();
        test_reset_mid();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
